// File: rtl/player_input_rx_if.sv
// Player input bundle between the capture block and its controller:
// capture controls going in, captured colour sequence and status coming out.
interface player_input_rx_if;
   logic        en;
   logic [3:0]  buttons;
   logic [3:0]  seq_len;
   logic [31:0] seq_out;
   logic        press_valid;
   logic [1:0]  press_colour;
   logic        complete;
   logic        timeout;
   logic        error;

   // Controller side: drives capture controls and raw buttons, observes results.
   modport master (
      output en, buttons, seq_len,
      input  seq_out, press_valid, press_colour, complete, timeout, error
   );

   // Capture block side.
   modport slave (
      input  en, buttons, seq_len,
      output seq_out, press_valid, press_colour, complete, timeout, error
   );
endinterface

// File: rtl/player_input_rx.sv
// Simon Says player input receiver: synchronises and debounces the four
// buttons, decodes each clean one-hot press into a 2-bit colour and packs the
// accepted colours in order into a 32-bit sequence word. One colour is
// accepted per press/release cycle; a missing press raises timeout and a
// stable multi-button press raises error.
module player_input_rx #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int TIMEOUT_CYCLES  = 16777215
) (
   input  logic              clk,
   input  logic              rst,
   player_input_rx_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, ARMED, WAIT_PRESS, DEB_PRESS, WAIT_REL, DONE, FAULT
   } state_t;

   // The debounce counter counts matching synchronised samples; a decision
   // is taken on the sample after DEBOUNCE_CYCLES+1 matches have been seen,
   // which lands the accept pulse DEBOUNCE_CYCLES+3 edges after the raw edge.
   localparam int            DW       = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES + 1);
   localparam logic [23:0]   TO_LAST  = 24'(TIMEOUT_CYCLES - 1);

   state_t        state_reg;
   logic [3:0]    sync1_reg;
   logic [3:0]    bs_reg;
   logic [3:0]    snap_reg;
   logic [DW-1:0] deb_cnt_reg;
   logic [23:0]   to_cnt_reg;
   logic [23:0]   to_cnt_next;
   logic [4:0]    count_reg;
   logic [4:0]    target_reg;
   logic [31:0]   seq_out_reg;
   logic          press_valid_reg;
   logic [1:0]    press_colour_reg;
   logic          complete_reg;
   logic          timeout_reg;
   logic          error_reg;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] encode(input logic [3:0] v);
      logic [1:0] c;
      case (v)
         4'b0010: c = 2'd1;
         4'b0100: c = 2'd2;
         4'b1000: c = 2'd3;
         default: c = 2'd0;
      endcase
      return c;
   endfunction

   // The wait timer saturates so a long debounce cannot wrap it past the limit.
   assign to_cnt_next = (to_cnt_reg == TO_LAST) ? to_cnt_reg : to_cnt_reg + 24'd1;

   // Two-flop synchroniser on the raw buttons; bs_reg is the only value used downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 4'd0;
         bs_reg    <= 4'd0;
      end else begin
         sync1_reg <= bus.buttons;
         bs_reg    <= sync1_reg;
      end
   end

   // Capture FSM with all outputs registered; en low always wins over acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         snap_reg         <= 4'd0;
         deb_cnt_reg      <= '0;
         to_cnt_reg       <= 24'd0;
         count_reg        <= 5'd0;
         target_reg       <= 5'd0;
         seq_out_reg      <= 32'd0;
         press_valid_reg  <= 1'b0;
         press_colour_reg <= 2'd0;
         complete_reg     <= 1'b0;
         timeout_reg      <= 1'b0;
         error_reg        <= 1'b0;
      end else begin
         press_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.en) begin
                  state_reg        <= ARMED;
                  seq_out_reg      <= 32'd0;
                  count_reg        <= 5'd0;
                  complete_reg     <= 1'b0;
                  timeout_reg      <= 1'b0;
                  error_reg        <= 1'b0;
                  press_colour_reg <= 2'd0;
                  target_reg       <= {1'b0, bus.seq_len} + 5'd1;
                  deb_cnt_reg      <= '0;
                  to_cnt_reg       <= 24'd0;
               end
            end

            ARMED: begin
               // A button held when capture starts must be released first.
               if (!bus.en) begin
                  state_reg <= IDLE;
               end else if (bs_reg != 4'd0) begin
                  deb_cnt_reg <= '0;
               end else if (deb_cnt_reg == DEB_LAST) begin
                  deb_cnt_reg <= '0;
                  to_cnt_reg  <= 24'd0;
                  state_reg   <= WAIT_PRESS;
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + DW'(1);
               end
            end

            WAIT_PRESS: begin
               if (!bus.en) begin
                  state_reg <= IDLE;
               end else if (bs_reg != 4'd0) begin
                  snap_reg    <= bs_reg;
                  deb_cnt_reg <= DW'(1);
                  to_cnt_reg  <= to_cnt_next;
                  state_reg   <= DEB_PRESS;
               end else if (to_cnt_reg == TO_LAST) begin
                  timeout_reg <= 1'b1;
                  state_reg   <= FAULT;
               end else begin
                  to_cnt_reg <= to_cnt_next;
               end
            end

            DEB_PRESS: begin
               if (!bus.en) begin
                  state_reg <= IDLE;
               end else if (bs_reg != snap_reg) begin
                  deb_cnt_reg <= '0;
                  to_cnt_reg  <= to_cnt_next;
                  state_reg   <= WAIT_PRESS;
               end else if (deb_cnt_reg == DEB_LAST) begin
                  deb_cnt_reg <= '0;
                  if (is_one_hot(snap_reg)) begin
                     // count < target <= 16 here, so the slot index stays in 0..15.
                     seq_out_reg[{count_reg[3:0], 1'b0} +: 2] <= encode(snap_reg);
                     press_colour_reg <= encode(snap_reg);
                     press_valid_reg  <= 1'b1;
                     count_reg        <= count_reg + 5'd1;
                     to_cnt_reg       <= 24'd0;
                     state_reg        <= WAIT_REL;
                  end else begin
                     error_reg <= 1'b1;
                     state_reg <= FAULT;
                  end
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + DW'(1);
                  to_cnt_reg  <= to_cnt_next;
               end
            end

            WAIT_REL: begin
               if (!bus.en) begin
                  state_reg <= IDLE;
               end else if (bs_reg != 4'd0) begin
                  deb_cnt_reg <= '0;
               end else if (deb_cnt_reg == DEB_LAST) begin
                  deb_cnt_reg <= '0;
                  if (count_reg == target_reg) begin
                     complete_reg <= 1'b1;
                     state_reg    <= DONE;
                  end else begin
                     to_cnt_reg <= 24'd0;
                     state_reg  <= WAIT_PRESS;
                  end
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + DW'(1);
               end
            end

            DONE, FAULT: begin
               if (!bus.en) begin
                  state_reg <= IDLE;
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.seq_out      = seq_out_reg;
   assign bus.press_valid  = press_valid_reg;
   assign bus.press_colour = press_colour_reg;
   assign bus.complete     = complete_reg;
   assign bus.timeout      = timeout_reg;
   assign bus.error        = error_reg;

endmodule

// File: tb/tb_player_input_rx.sv
// Directed bench for player_input_rx with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_player_input_rx;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pv_count = 0;
   int cmp_cyc  = 0;
   logic cmp_prev = 1'b0;
   logic [1:0] colour_log [$];
   int         cyc_log    [$];

   player_input_rx_if bus();

   player_input_rx #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Edge counter: cyc equals the number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Log every accepted colour and the first cycle of each complete assertion.
   always @(negedge clk) begin
      if (bus.press_valid) begin
         pv_count = pv_count + 1;
         colour_log.push_back(bus.press_colour);
         cyc_log.push_back(cyc);
         $display("press accepted: colour=%0d edge=%0d seq_out=%h",
                  bus.press_colour, cyc, bus.seq_out);
      end
      if (bus.complete && !cmp_prev) cmp_cyc = cyc;
      cmp_prev = bus.complete;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Press pattern for 'hold' cycles, release for 'gap'; returns the first
   // edges that sample the press and the release.
   task automatic press(input logic [3:0] pat, input int hold, input int gap,
                        output int start, output int rel);
      bus.buttons = pat;
      start = cyc + 1;
      tick(hold);
      bus.buttons = 4'd0;
      rel = cyc + 1;
      tick(gap);
   endtask

   task automatic start_cap(input logic [3:0] len);
      bus.en = 1'b0;
      tick(2);
      bus.seq_len = len;
      bus.en = 1'b1;
      tick(10);
   endtask

   initial begin
      int base, s, r, s0, r0;
      bus.en = 1'b0;
      bus.buttons = 4'd0;
      bus.seq_len = 4'd0;

      // Reset state, asserted asynchronously before the first clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_seq_out", bus.seq_out, 32'd0);
      check("rst_pv", {31'd0, bus.press_valid}, 32'd0);
      check("rst_flags", {29'd0, bus.complete, bus.timeout, bus.error}, 32'd0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Basic capture: colours 0, 2, 3.
      start_cap(4'd2);
      base = pv_count;
      press(4'b0001, 10, 10, s0, r0);
      press(4'b0100, 10, 10, s, r);
      press(4'b1000, 10, 10, s, r);
      check("t1_pv_count", 32'(pv_count - base), 32'd3);
      check("t1_col0", {30'd0, colour_log[base]}, 32'd0);
      check("t1_col1", {30'd0, colour_log[base+1]}, 32'd2);
      check("t1_col2", {30'd0, colour_log[base+2]}, 32'd3);
      check("t1_pv_latency", 32'(cyc_log[base] - s0), 32'd7);
      check("t1_seq_out", bus.seq_out, 32'h0000_0038);
      check("t1_complete", {31'd0, bus.complete}, 32'd1);
      check("t1_cmp_latency", 32'(cmp_cyc - r), 32'd7);
      check("t1_err_to", {30'd0, bus.error, bus.timeout}, 32'd0);

      // Bouncing colour 1 press.
      start_cap(4'd0);
      base = pv_count;
      for (int i = 0; i < 3; i++) begin
         bus.buttons = 4'b0010;
         tick(2);
         bus.buttons = 4'd0;
         tick(2);
      end
      press(4'b0010, 10, 10, s, r);
      check("t2_pv_count", 32'(pv_count - base), 32'd1);
      check("t2_colour", {30'd0, bus.press_colour}, 32'd1);
      check("t2_pv_latency", 32'(cyc_log[base] - s), 32'd7);
      check("t2_complete", {31'd0, bus.complete}, 32'd1);

      // Stable multi-button press.
      start_cap(4'd0);
      base = pv_count;
      press(4'b0011, 10, 10, s, r);
      check("t3_error", {31'd0, bus.error}, 32'd1);
      check("t3_pv_count", 32'(pv_count - base), 32'd0);
      check("t3_seq_out", bus.seq_out, 32'd0);
      check("t3_complete", {31'd0, bus.complete}, 32'd0);

      // Button held before capture starts.
      bus.en = 1'b0;
      tick(2);
      base = pv_count;
      bus.buttons = 4'b0001;
      bus.seq_len = 4'd0;
      bus.en = 1'b1;
      tick(2);
      check("t3b_err_clear", {31'd0, bus.error}, 32'd0);
      tick(13);
      check("t3b_no_accept", 32'(pv_count - base), 32'd0);
      bus.buttons = 4'd0;
      tick(10);
      press(4'b0100, 10, 10, s, r);
      check("t3b_pv_count", 32'(pv_count - base), 32'd1);
      check("t3b_colour", {30'd0, bus.press_colour}, 32'd2);
      check("t3b_seq_out", bus.seq_out, 32'h0000_0002);
      check("t3b_complete", {31'd0, bus.complete}, 32'd1);

      // Timeout: en sampled at edge A0, WAIT_PRESS from A6, timeout after A70.
      bus.en = 1'b0;
      tick(2);
      bus.seq_len = 4'd3;
      bus.en = 1'b1;
      tick(70);
      check("t4_before", {31'd0, bus.timeout}, 32'd0);
      tick(1);
      check("t4_timeout", {31'd0, bus.timeout}, 32'd1);
      check("t4_complete", {31'd0, bus.complete}, 32'd0);
      bus.en = 1'b0;
      tick(3);
      check("t4_held", {31'd0, bus.timeout}, 32'd1);
      bus.en = 1'b1;
      tick(1);
      check("t4_cleared", {31'd0, bus.timeout}, 32'd0);

      // Full 16-press capture.
      start_cap(4'd15);
      base = pv_count;
      for (int i = 0; i < 16; i++) press(4'b1000, 10, 10, s, r);
      check("t5_pv_count", 32'(pv_count - base), 32'd16);
      check("t5_seq_out", bus.seq_out, 32'hFFFF_FFFF);
      check("t5_complete", {31'd0, bus.complete}, 32'd1);

      // Repeat, then asynchronous reset after the third press.
      start_cap(4'd15);
      base = pv_count;
      for (int i = 0; i < 3; i++) press(4'b1000, 10, 10, s, r);
      check("t6_pv_count", 32'(pv_count - base), 32'd3);
      check("t6_seq_out", bus.seq_out, 32'h0000_003F);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_seq_out", bus.seq_out, 32'd0);
      check("t6_rst_colour", {30'd0, bus.press_colour}, 32'd0);
      check("t6_rst_flags", {28'd0, bus.press_valid, bus.complete, bus.timeout, bus.error}, 32'd0);
      tick(2);
      rst = 1'b0;
      bus.en = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
